multdiv_unit: RTL and testbench
===============================

# multdiv_unit

Sequential signed 32-bit multiply/divide unit in the execute stage, beside the ALU and its arithmetic shifter. The ALU handles single-cycle add/sub/logic/shift opcodes. MULT and DIV opcodes go to this block, and the pipeline stalls until `data_resultRDY`. Multiply uses radix-2 Booth recoding with a one-bit arithmetic right shift per iteration. Divide is restoring division on magnitudes, followed by a sign fix-up.

## Interface

Parameters:

- `WIDTH`, 32: operand and result width.
- `COUNT_W`, 6: iteration counter width; must hold `WIDTH`.

Ports:

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_operandA`  in  WIDTH  multiplicand or dividend (two's complement); sampled only on a start edge.
- `data_operandB`  in  WIDTH  multiplier or divisor (two's complement); sampled only on a start edge.
- `ctrl_MULT`  in  1  single-cycle start pulse for multiply.
- `ctrl_DIV`  in  1  single-cycle start pulse for divide.
- `data_result`  out  WIDTH  low WIDTH bits of the product, or the quotient.
- `data_exception`  out  1  overflow or divide-by-zero flag; valid while `data_resultRDY`=1.
- `data_resultRDY`  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, MULT, DIV, DONE. All outputs are registered.
- Reset (`reset_n`=0 at an edge):
  - state IDLE, counter 0;
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0;
  - any in-flight operation is discarded, with no RDY.
- Start: `ctrl_MULT` or `ctrl_DIV` high at an edge, in any state.
  - The operands are latched.
  - The counter clears.
  - State moves to MULT or DIV.
  - Both high at once: treated as MULT.
  - A start in MULT/DIV aborts the current operation silently; no RDY is produced for it.
- MULT:
  - Product register P is 2·WIDTH+1 bits, initialised {0, B, 0}.
  - Each iteration, P[1:0] selects the step: 01 adds A to the upper WIDTH bits, 10 subtracts A, 00 and 11 do nothing.
  - The add/sub is WIDTH+1 bits wide, sign-extended, so that A = 0x80000000 is correct.
  - P is then shifted arithmetic-right by 1.
  - After WIDTH iterations: result is the low WIDTH bits of the product.
  - Exception = 1 iff the upper WIDTH bits of the product ≠ WIDTH copies of product bit WIDTH-1.
- DIV:
  - At the start edge:
    - If B=0: go directly to DONE with result 0 and exception 1.
    - Otherwise latch |A| and |B|, the quotient sign sA^sB, and clear the remainder register.
  - Each iteration:
    - Shift {R, Q} left by one.
    - Trial subtract R−|B| (WIDTH+1 bits).
    - If the trial is non-negative, R takes the difference and Q[0]=1; otherwise Q[0]=0.
  - After WIDTH iterations: quotient = Q, negated if the sign is set. Truncation is toward zero; the remainder is discarded.
  - A=0x80000000, B=−1: result 0x80000000, exception 1.
  - All other nonzero divisors give exception 0.
- DONE:
  - `data_resultRDY`=1 for one cycle, then state returns to IDLE.
  - `data_result` and `data_exception` hold until the next start or reset.

## Timing

- Let E0 be the start edge. Iterations occur on E1..E32; the result registers load on E32 and state becomes DONE.
- `data_resultRDY` is high in the cycle between E32 and E33, which is 33 edges after the start. It is low after E33.
- Divide-by-zero: RDY is high in the cycle between E0 and E1.
- A start at the edge that ends DONE is legal. RDY is still high during that DONE cycle, falls on the start edge, and the new operation proceeds normally.
- The operand inputs may change freely after E0.
- Throughput: one operation per 33 cycles.

## Structure

- Shared package `multdiv_pkg` holds:
  - the state encoding constants IDLE/MULT/DIV/DONE;
  - `WIDTH` and `COUNT_W` defaults;
  - the `ITER_LAST` constant (WIDTH−1).
- One combinational sub-module, `div_step`:
  - inputs: R, Q, |B|;
  - outputs: the next R and Q.
  - Booth add/sub and shift stay inline.
- Top: controller FSM, iteration counter, P/R/Q datapath registers, sign fix-up and overflow detect.

## Test plan

- 7 × −3 (ctrl_MULT) -> `data_result`=0xFFFFFFEB, exception 0, RDY exactly in the 33rd cycle after start, high for one cycle.
- 0x00010000 × 0x00010000 -> result 0x00000000, exception 1; also 0x80000000 × 1 -> 0x80000000, exception 0.
- −7 ÷ 2 -> 0xFFFFFFFD; 100 ÷ 7 -> 0x0000000E; both exception 0 with 33-cycle latency.
- 5 ÷ 0 -> result 0, exception 1, RDY in the cycle after the start edge; 0x80000000 ÷ −1 -> 0x80000000, exception 1.
- Abort: start 3×4, then 10 cycles later start 100÷7 -> exactly one RDY, 33 cycles after the second start, result 14.
- `reset_n` low at iteration 15 of a multiply, then held high -> all outputs 0 and no RDY ever appears; both start pulses together -> multiply performed.

Source files
------------

// File: rtl/multdiv_pkg.sv
// ============================================================================
//  Module   : multdiv_pkg
//  Purpose  : Shared state encoding and sizing constants for multdiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package multdiv_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_COUNT_W = 6;
    localparam int ITER_LAST  = MD_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/multdiv_unit_div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One restoring-division iteration on magnitudes (combinational).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] bmag_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ok;

    // Extra top bit acts as the borrow of the trial subtraction.
    assign w_shift = {r_i, q_i[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, bmag_i};
    assign w_ok    = ~w_diff[WIDTH];

    assign r_o = w_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], w_ok};

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Sequential signed multiply (radix-2 Booth) / restoring divide.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH,
    parameter int COUNT_W = MD_COUNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [COUNT_W-1:0] C_LAST_CNT = COUNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_p_next;
    logic [WIDTH-1:0]   w_r_next;
    logic [WIDTH-1:0]   w_q_next;

    // Booth step on a WIDTH+1 sum so the most negative multiplicand keeps its sign.
    assign w_hi = p_q[2*WIDTH:WIDTH+1];

    always_comb begin
        unique case (p_q[1:0])
            2'b01:   w_sum = {w_hi[WIDTH-1], w_hi} + {a_q[WIDTH-1], a_q};
            2'b10:   w_sum = {w_hi[WIDTH-1], w_hi} - {a_q[WIDTH-1], a_q};
            default: w_sum = {w_hi[WIDTH-1], w_hi};
        endcase
    end

    assign w_p_next = {w_sum, p_q[WIDTH:1]};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .r_i    (r_q),
        .q_i    (qr_q),
        .bmag_i (bmag_q),
        .r_o    (w_r_next),
        .q_o    (w_q_next)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        p_d      = p_q;
        r_d      = r_q;
        qr_d     = qr_q;
        bmag_d   = bmag_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        unique case (state_q)
            MULT: begin
                p_d   = w_p_next;
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d  = DONE;
                    result_d = w_p_next[WIDTH:1];
                    exc_d    = (w_p_next[2*WIDTH:WIDTH+1] != {WIDTH{w_p_next[WIDTH]}});
                    rdy_d    = 1'b1;
                end
            end
            DIV: begin
                r_d   = w_r_next;
                qr_d  = w_q_next;
                cnt_d = cnt_q + COUNT_W'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d  = DONE;
                    result_d = sign_q ? -w_q_next : w_q_next;
                    // A positive quotient with its top bit set only arises from MIN / -1.
                    exc_d    = ~sign_q & w_q_next[WIDTH-1];
                    rdy_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ctrl_MULT) begin
            state_d = MULT;
            cnt_d   = '0;
            a_d     = data_operandA;
            p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            rdy_d   = 1'b0;
        end else if (ctrl_DIV) begin
            cnt_d = '0;
            if (data_operandB == '0) begin
                state_d  = DONE;
                result_d = '0;
                exc_d    = 1'b1;
                rdy_d    = 1'b1;
            end else begin
                state_d = DIV;
                qr_d    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                bmag_d  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
                sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_d     = '0;
                rdy_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
            qr_q     <= '0;
            bmag_q   <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            p_q      <= p_d;
            r_q      <= r_d;
            qr_q     <= qr_d;
            bmag_q   <= bmag_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
//  Module   : tb_multdiv_unit
//  Purpose  : Directed self-checking bench for multdiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multdiv_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks;
    int failures;

    multdiv_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns at the negedge inside the cycle that follows the start edge.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
    endtask

    // lat = number of cycles after the post-start cycle at which RDY is seen; -1 on timeout.
    task automatic wait_rdy(input int budget, output int lat);
        lat = -1;
        for (int k = 0; k <= budget; k++) begin
            if (data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
    endtask

    task automatic test_mult();
        int lat;
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL mul_7x-3_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_7x-3_result got=%h exp=ffffffeb", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL mul_7x-3_exc got=%b exp=0", data_exception); end
        @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL mul_rdy_pulse got=%b exp=0", data_resultRDY); end

        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL mul_ovf_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL mul_ovf_result got=%h exp=00000000", data_result); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL mul_ovf_exc got=%b exp=1", data_exception); end

        start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        wait_rdy(40, lat);
        checks++; if (data_result !== 32'h8000_0000) begin failures++; $display("FAIL mul_min_result got=%h exp=80000000", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL mul_min_exc got=%b exp=0", data_exception); end
    endtask

    task automatic test_div();
        int lat;
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL div_-7/2_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_-7/2_result got=%h exp=fffffffd", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL div_-7/2_exc got=%b exp=0", data_exception); end

        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL div_100/7_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'h0000_000E) begin failures++; $display("FAIL div_100/7_result got=%h exp=0000000e", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL div_100/7_exc got=%b exp=0", data_exception); end
    endtask

    task automatic test_div_boundary();
        int lat;
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        wait_rdy(40, lat);
        checks++; if (lat !== 0) begin failures++; $display("FAIL div_by0_latency got=%0d exp=0", lat); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL div_by0_result got=%h exp=00000000", data_result); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL div_by0_exc got=%b exp=1", data_exception); end
        @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL div_by0_rdy_pulse got=%b exp=0", data_resultRDY); end

        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(40, lat);
        checks++; if (data_result !== 32'h8000_0000) begin failures++; $display("FAIL div_min/-1_result got=%h exp=80000000", data_result); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL div_min/-1_exc got=%b exp=1", data_exception); end
        repeat (3) @(negedge clock);
        checks++; if (data_result !== 32'h8000_0000) begin failures++; $display("FAIL result_hold got=%h exp=80000000", data_result); end
    endtask

    task automatic test_abort();
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        for (int k = 0; k < 9; k++) begin
            if (data_resultRDY === 1'b1) pulses++;
            @(negedge clock);
        end
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        for (int k = 0; k < 40; k++) begin
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 32) begin
                checks++; if (data_result !== 32'h0000_000E) begin failures++; $display("FAIL abort_result got=%h exp=0000000e", data_result); end
            end
            @(negedge clock);
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL abort_rdy_count got=%0d exp=1", pulses); end
        checks++; if (first !== 32) begin failures++; $display("FAIL abort_latency got=%0d exp=32", first); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL midreset_exc got=%b exp=0", data_exception); end
        for (int k = 0; k < 40; k++) begin
            if (data_resultRDY !== 1'b0) pulses++;
            @(negedge clock);
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_rdy_cycles got=%0d exp=0", pulses); end
    endtask

    task automatic test_both_starts();
        int lat;
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL both_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'd18) begin failures++; $display("FAIL both_result got=%h exp=00000012", data_result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        wait_rdy(40, lat);
        checks++; if (data_result !== 32'd30) begin failures++; $display("FAIL b2b_first_result got=%h exp=0000001e", data_result); end
        // Start lands on the edge that closes the DONE cycle.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'hFFFF_FF9C;
        data_operandB = 32'd7;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL b2b_rdy_fall got=%b exp=0", data_resultRDY); end
        wait_rdy(40, lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=32", lat); end
        checks++; if (data_result !== 32'hFFFF_FFF2) begin failures++; $display("FAIL b2b_second_result got=%h exp=fffffff2", data_result); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div_boundary();
        test_abort();
        test_reset_mid();
        test_both_starts();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
